h264recon_gen: RTL and testbench

H264RECON_GEN -- requirements
Module: h264recon_gen

---
 rtl/h264recon_pkg.sv | 32 +++
 rtl/h264recon_fifo.sv | 78 +++++++
 rtl/h264recon_gen.sv | 137 +++++++++++++
 tb/tb_h264recon_gen.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/h264recon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : h264recon_pkg
// Purpose  : Shared defaults, base-FIFO entry layout and sample clip helper.
// Revision : 1.0
// ============================================================================
package h264recon_pkg;

  localparam int c_lanes    = 4;
  localparam int c_bitdepth = 8;
  localparam int c_resw     = 10;
  localparam int c_depth    = 8;

  // Entry layout at the default geometry; the FIFO packs {base, chroma} the same way.
  typedef struct packed {
    logic [c_lanes*c_bitdepth-1:0] base;
    logic                          chroma;
  } recon_entry_t;

  function automatic logic [31:0] clip(input logic signed [31:0] sum, input int bitdepth);
    logic signed [31:0] maxv;
    maxv = (32'sd1 <<< bitdepth) - 32'sd1;
    if (sum < 32'sd0)
      clip = '0;
    else if (sum > maxv)
      clip = maxv;
    else
      clip = sum;
  endfunction

endpackage
`default_nettype wire

// File: rtl/h264recon_fifo.sv
`default_nettype none
// ============================================================================
// Module   : h264recon_fifo
// Purpose  : Base-sample FIFO with per-entry chroma flag, occupancy and ready.
// Revision : 1.0
// ============================================================================
module h264recon_fifo
  import h264recon_pkg::*;
#(
  parameter int LANES    = c_lanes,
  parameter int BITDEPTH = c_bitdepth,
  parameter int DEPTH    = c_depth
) (
  input  logic                          CLK2,
  input  logic                          RESET,
  input  logic                          i_flush,
  input  logic                          i_push,
  input  logic                          i_chroma,
  input  logic [LANES*BITDEPTH-1:0]     i_base,
  input  logic                          i_pop,
  output logic                          o_ready,
  output logic [$clog2(DEPTH):0]        o_level,
  output logic [LANES*BITDEPTH-1:0]     o_base,
  output logic                          o_chroma
);

  localparam int            c_aw   = $clog2(DEPTH);
  localparam int            c_ew   = LANES*BITDEPTH + 1;
  localparam logic [c_aw:0] c_full = (c_aw+1)'(DEPTH);

  logic [c_ew-1:0] r_mem [DEPTH];
  logic [c_aw-1:0] r_wptr;
  logic [c_aw-1:0] r_rptr;
  logic [c_aw:0]   r_level;
  logic [c_ew-1:0] w_rd;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;

  assign w_empty = (r_level == '0);
  assign o_ready = (r_level < c_full);
  assign w_push  = i_push & o_ready & ~i_flush;
  assign w_pop   = i_pop & ~w_empty & ~i_flush;

  always_ff @(posedge CLK2 or posedge RESET) begin
    if (RESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)
        r_level <= r_level + 1'b1;
      else if (w_pop && !w_push)
        r_level <= r_level - 1'b1;
    end
  end

  // Storage is deliberately left out of reset; occupancy alone qualifies reads.
  always_ff @(posedge CLK2) begin
    if (w_push)
      r_mem[r_wptr] <= {i_base, i_chroma};
  end

  assign w_rd     = r_mem[r_rptr];
  assign o_base   = w_empty ? '0 : w_rd[c_ew-1:1];
  assign o_chroma = ~w_empty & w_rd[0];
  assign o_level  = r_level;

endmodule
`default_nettype wire

// File: rtl/h264recon_gen.sv
`default_nettype none
// ============================================================================
// Module   : h264recon_gen
// Purpose  : Two-stage base+residual reconstruction with clip and luma/chroma
//            strobes. Define H264RECON_GEN_ERR_EN for sticky ERRO and checks.
// Revision : 1.0
// ============================================================================
module h264recon_gen
  import h264recon_pkg::*;
#(
  parameter int LANES    = c_lanes,
  parameter int BITDEPTH = c_bitdepth,
  parameter int RESW     = c_resw,
  parameter int DEPTH    = c_depth
) (
  input  logic                          CLK2,
  input  logic                          RESET,
  input  logic                          NEWSLICE,
  input  logic                          STROBEI,
  input  logic [LANES*RESW-1:0]         DATAI,
  input  logic                          BSTROBEI,
  input  logic                          BCHROMAI,
  input  logic [LANES*BITDEPTH-1:0]     BASEI,
  output logic                          BREADY,
  output logic [$clog2(DEPTH):0]        LEVEL,
  output logic                          STROBEO,
  output logic                          CSTROBEO,
  output logic [LANES*BITDEPTH-1:0]     DATAO,
  output logic [1:0]                    ERRO
);

  logic [LANES*BITDEPTH-1:0] w_base;
  logic                      w_chroma;
  logic                      w_accept;
  logic signed [RESW:0]      w_sum    [LANES];

  logic                      r_s1_valid;
  logic                      r_s1_chroma;
  logic signed [RESW:0]      r_s1_sum [LANES];
  logic                      r_strobeo;
  logic                      r_cstrobeo;
  logic [LANES*BITDEPTH-1:0] r_datao;

  h264recon_fifo #(
    .LANES    (LANES),
    .BITDEPTH (BITDEPTH),
    .DEPTH    (DEPTH)
  ) u_fifo (
    .CLK2     (CLK2),
    .RESET    (RESET),
    .i_flush  (NEWSLICE),
    .i_push   (BSTROBEI),
    .i_chroma (BCHROMAI),
    .i_base   (BASEI),
    .i_pop    (STROBEI),
    .o_ready  (BREADY),
    .o_level  (LEVEL),
    .o_base   (w_base),
    .o_chroma (w_chroma)
  );

  // An empty FIFO still yields a beat: the FIFO presents base 0 / luma.
  assign w_accept = STROBEI & ~NEWSLICE;

  always_comb begin
    w_sum = '{default: '0};
    for (int k = 0; k < LANES; k++) begin
      w_sum[k] = $signed({{(RESW+1-BITDEPTH){1'b0}}, w_base[k*BITDEPTH +: BITDEPTH]})
               + $signed({DATAI[k*RESW+RESW-1], DATAI[k*RESW +: RESW]});
    end
  end

  always_ff @(posedge CLK2 or posedge RESET) begin
    if (RESET) begin
      r_s1_valid  <= 1'b0;
      r_s1_chroma <= 1'b0;
      r_s1_sum    <= '{default: '0};
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_chroma <= w_chroma;
        r_s1_sum    <= w_sum;
      end
    end
  end

  // NEWSLICE does not touch this stage, so beats already in flight drain out.
  always_ff @(posedge CLK2 or posedge RESET) begin
    if (RESET) begin
      r_strobeo  <= 1'b0;
      r_cstrobeo <= 1'b0;
      r_datao    <= '0;
    end else begin
      r_strobeo  <= r_s1_valid & ~r_s1_chroma;
      r_cstrobeo <= r_s1_valid & r_s1_chroma;
      if (r_s1_valid) begin
        for (int k = 0; k < LANES; k++)
          r_datao[k*BITDEPTH +: BITDEPTH] <= BITDEPTH'(clip(32'(r_s1_sum[k]), BITDEPTH));
      end
    end
  end

  assign STROBEO  = r_strobeo;
  assign CSTROBEO = r_cstrobeo;
  assign DATAO    = r_datao;

`ifdef H264RECON_GEN_ERR_EN
  logic [1:0] r_erro;
  logic       w_ovf;
  logic       w_udf;

  assign w_ovf = BSTROBEI & ~BREADY & ~NEWSLICE;
  assign w_udf = STROBEI & (LEVEL == '0) & ~NEWSLICE;

  always_ff @(posedge CLK2 or posedge RESET) begin
    if (RESET)
      r_erro <= 2'b00;
    else if (NEWSLICE)
      r_erro <= 2'b00;
    else
      r_erro <= r_erro | {w_udf, w_ovf};
  end

  assign ERRO = r_erro;

  always @(posedge CLK2) begin
    if (!RESET) begin
      a_no_overflow : assert (!w_ovf) else $warning("h264recon_gen: base beat dropped while full");
      a_no_underflow: assert (!w_udf) else $warning("h264recon_gen: residual beat with empty base FIFO");
    end
  end
`else
  assign ERRO = 2'b00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_h264recon_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_h264recon_gen
// Purpose  : Directed scoreboard bench for h264recon_gen at default geometry.
// Revision : 1.0
// ============================================================================
module tb_h264recon_gen;

  localparam int LANES    = 4;
  localparam int BITDEPTH = 8;
  localparam int RESW     = 10;
  localparam int DEPTH    = 8;
`ifdef H264RECON_GEN_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        CLK2;
  logic        RESET;
  logic        NEWSLICE;
  logic        STROBEI;
  logic [39:0] DATAI;
  logic        BSTROBEI;
  logic        BCHROMAI;
  logic [31:0] BASEI;
  logic        BREADY;
  logic [3:0]  LEVEL;
  logic        STROBEO;
  logic        CSTROBEO;
  logic [31:0] DATAO;
  logic [1:0]  ERRO;

  typedef struct {
    logic [31:0] data;
    logic        chroma;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [32:0] mq[$];
  logic [1:0]  merr = 2'b00;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  h264recon_gen #(
    .LANES    (LANES),
    .BITDEPTH (BITDEPTH),
    .RESW     (RESW),
    .DEPTH    (DEPTH)
  ) dut (
    .CLK2     (CLK2),
    .RESET    (RESET),
    .NEWSLICE (NEWSLICE),
    .STROBEI  (STROBEI),
    .DATAI    (DATAI),
    .BSTROBEI (BSTROBEI),
    .BCHROMAI (BCHROMAI),
    .BASEI    (BASEI),
    .BREADY   (BREADY),
    .LEVEL    (LEVEL),
    .STROBEO  (STROBEO),
    .CSTROBEO (CSTROBEO),
    .DATAO    (DATAO),
    .ERRO     (ERRO)
  );

  initial begin
    CLK2 = 1'b0;
    forever #5 CLK2 = ~CLK2;
  end

  always @(posedge CLK2) cyc <= cyc + 1;

  function automatic logic [31:0] recon(input logic [31:0] base, input logic [39:0] res);
    logic [31:0] out;
    int b, r, s;
    out = '0;
    for (int k = 0; k < 4; k++) begin
      b = int'(base[k*8 +: 8]);
      r = $signed(res[k*10 +: 10]);
      s = b + r;
      if (s < 0) s = 0;
      if (s > 255) s = 255;
      out[k*8 +: 8] = s[7:0];
    end
    return out;
  endfunction

  function automatic logic [39:0] rnd_res();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[39:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at a negedge, update the model, check state at the next negedge.
  task automatic step(input logic si, input logic [39:0] res, input logic bsi,
                      input logic bch, input logic [31:0] base, input logic ns);
    logic [32:0] e;
    exp_t        x;
    int          lvl0;
    STROBEI  = si;
    DATAI    = res;
    BSTROBEI = bsi;
    BCHROMAI = bch;
    BASEI    = base;
    NEWSLICE = ns;
    lvl0 = mq.size();
    if (ns) begin
      mq.delete();
      merr = 2'b00;
    end else begin
      if (si) begin
        if (lvl0 > 0) begin
          e = mq.pop_front();
        end else begin
          e = '0;
          merr[1] = 1'b1;
        end
        x.data   = recon(e[32:1], res);
        x.chroma = e[0];
        x.cyc    = cyc + 2;
        sb.push_back(x);
      end
      if (bsi) begin
        if (lvl0 < DEPTH) mq.push_back({base, bch});
        else merr[0] = 1'b1;
      end
    end
    @(negedge CLK2);
    STROBEI  = 1'b0;
    BSTROBEI = 1'b0;
    NEWSLICE = 1'b0;
    check("level", LEVEL, mq.size());
    check("bready", BREADY, (mq.size() < DEPTH) ? 1 : 0);
    check("erro", ERRO, ERR_EN ? merr : 2'b00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // Output monitor: every beat must match the scoreboard front, at the expected cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK2);
      if (RESET === 1'b0) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
          check("missing_beat", cyc, sb[0].cyc);
          void'(sb.pop_front());
        end
        if (STROBEO || CSTROBEO) begin
          if (sb.size() == 0) begin
            check("spurious_beat", {STROBEO, CSTROBEO}, 2'b00);
          end else begin
            e = sb.pop_front();
            check("beat_flags", {STROBEO, CSTROBEO}, {~e.chroma, e.chroma});
            check("beat_data", DATAO, e.data);
            check("beat_latency", cyc, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    RESET    = 1'b1;
    NEWSLICE = 1'b0;
    STROBEI  = 1'b0;
    DATAI    = '0;
    BSTROBEI = 1'b0;
    BCHROMAI = 1'b0;
    BASEI    = '0;

    @(negedge CLK2);
    check("rst_strobeo", STROBEO, 1'b0);
    check("rst_cstrobeo", CSTROBEO, 1'b0);
    check("rst_datao", DATAO, 32'h0);
    check("rst_erro", ERRO, 2'b00);
    check("rst_level", LEVEL, 4'd0);
    check("rst_bready", BREADY, 1'b1);
    @(negedge CLK2);
    RESET = 1'b0;

    // Basic reconstruction with clipping on both ends.
    step(1'b0, '0, 1'b1, 1'b0, 32'h10203040, 1'b0);
    step(1'b1, {10'd0, 10'h1FF, 10'h3B0, 10'd5}, 1'b0, 1'b0, '0, 1'b0);
    idle(1);
    check("basic_data", DATAO, 32'h10FF0045);
    check("basic_strobeo", STROBEO, 1'b1);
    idle(1);
    check("hold_data", DATAO, 32'h10FF0045);
    check("hold_strobeo", STROBEO, 1'b0);

    // Fill to DEPTH, overflow a 9th, then drain in order (first pop also pushes while full).
    for (int i = 0; i < 8; i++)
      step(1'b0, '0, 1'b1, 1'b0, 32'hA0B0C0D0 + i * 32'h01010101, 1'b0);
    check("full_level", LEVEL, 4'd8);
    check("full_bready", BREADY, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0);
    check("ovf_erro", ERRO, ERR_EN ? 2'b01 : 2'b00);
    for (int i = 0; i < 8; i++)
      step(1'b1, '0, (i == 0), 1'b0, 32'h55555555, 1'b0);
    idle(3);

    // Chroma flag travels per entry.
    for (int i = 0; i < 4; i++)
      step(1'b0, '0, 1'b1, i[0], $urandom(), 1'b0);
    for (int i = 0; i < 4; i++)
      step(1'b1, rnd_res(), 1'b0, 1'b0, '0, 1'b0);
    idle(3);

    // Slice flush with beats in flight; same-cycle strobes ignored.
    for (int i = 0; i < 7; i++)
      step(1'b0, '0, 1'b1, 1'b0, $urandom(), 1'b0);
    step(1'b1, rnd_res(), 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, rnd_res(), 1'b0, 1'b0, '0, 1'b0);
    check("pre_flush_level", LEVEL, 4'd5);
    step(1'b1, rnd_res(), 1'b1, 1'b0, $urandom(), 1'b1);
    check("flush_level", LEVEL, 4'd0);
    check("flush_erro", ERRO, 2'b00);
    idle(3);

    // Underflow: base 0 substituted.
    step(1'b1, {4{10'h007}}, 1'b0, 1'b0, '0, 1'b0);
    idle(1);
    check("udf_data", DATAO, 32'h07070707);
    check("udf_strobeo", STROBEO, 1'b1);
    check("udf_erro", ERRO, ERR_EN ? 2'b10 : 2'b00);

    // Push and pop together at empty (no bypass), then mid-level.
    step(1'b1, rnd_res(), 1'b1, 1'b1, $urandom(), 1'b0);
    check("pushpop_empty_level", LEVEL, 4'd1);
    step(1'b0, '0, 1'b1, 1'b0, $urandom(), 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, $urandom(), 1'b0);
    step(1'b1, rnd_res(), 1'b1, 1'b0, $urandom(), 1'b0);
    check("pushpop_mid_level", LEVEL, 4'd3);
    idle(3);

    // Asynchronous reset between edges while beats are in flight.
    step(1'b1, rnd_res(), 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, rnd_res(), 1'b0, 1'b0, '0, 1'b0);
    #1;
    RESET = 1'b1;
    #1;
    check("arst_strobeo", STROBEO, 1'b0);
    check("arst_cstrobeo", CSTROBEO, 1'b0);
    check("arst_datao", DATAO, 32'h0);
    check("arst_erro", ERRO, 2'b00);
    check("arst_level", LEVEL, 4'd0);
    check("arst_bready", BREADY, 1'b1);
    mq.delete();
    sb.delete();
    merr = 2'b00;
    @(negedge CLK2);
    @(negedge CLK2);
    RESET = 1'b0;

    step(1'b0, '0, 1'b1, 1'b1, 32'h80FF0001, 1'b0);
    step(1'b1, {10'h3FF, 10'h001, 10'h3FF, 10'h001}, 1'b0, 1'b0, '0, 1'b0);
    idle(3);
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
